// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM encoding, frame constants and the
// register address map also used by the DDS register block.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAddr  = 3'd1,
        StDataH = 3'd2,
        StDataL = 3'd3,
        StChk   = 3'd4
    } cmd_state_e;

    localparam logic [7:0]  DefaultHeader = 8'h55;
    localparam int unsigned FrameLen      = 5;

    localparam logic [7:0] AddrDdsEn     = 8'd6;
    localparam logic [7:0] AddrFwordH    = 8'd7;
    localparam logic [7:0] AddrFwordL    = 8'd8;
    localparam logic [7:0] AddrPword     = 8'd9;
    localparam logic [7:0] AddrSCntMaxL  = 8'd10;
    localparam logic [7:0] AddrSCntMaxH  = 8'd11;
    localparam logic [7:0] AddrSampleEn  = 8'd12;

    // Checksum is the 8-bit truncating sum of the three payload bytes.
    function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
        return a + b + c;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte watchdog: counts idle cycles and flags the terminal count unless cleared that cycle.
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned TO_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);

    logic [TO_W-1:0] cnt_q;

    assign tc = !clr && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || tc) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte UART command frames (header, addr, data_hi, data_lo, checksum) and issues
// one register write per valid frame; bad checksums and stalled frames pulse Frame_Err.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  HEADER         = DefaultHeader,
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned TO_W           = 19
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  Rx_Data,
    input  logic        Rx_Done,
    output logic        m_wr,
    output logic [7:0]  m_addr,
    output logic [15:0] m_wrdata,
    output logic        Frame_Err,
    output logic        Busy
);

    cmd_state_e  state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic [7:0]  data_lo_q, data_lo_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [7:0]  m_addr_q, m_addr_d;
    logic [15:0] m_wrdata_q, m_wrdata_d;
    logic        to_clr;
    logic        to_tc;

    assign to_clr = Rx_Done || (state_q == StIdle);

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk (Clk),
        .rst (Rst),
        .clr (to_clr),
        .tc  (to_tc)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_hi_d  = data_hi_q;
        data_lo_d  = data_lo_q;
        wr_d       = 1'b0;
        err_d      = 1'b0;
        m_addr_d   = m_addr_q;
        m_wrdata_d = m_wrdata_q;

        // to_tc can only fire with Rx_Done low, so a byte on the terminal count is processed.
        if (to_tc) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end else if (Rx_Done) begin
            case (state_q)
                StIdle: begin
                    if (Rx_Data == HEADER) begin
                        state_d = StAddr;
                    end
                end
                StAddr: begin
                    addr_d  = Rx_Data;
                    state_d = StDataH;
                end
                StDataH: begin
                    data_hi_d = Rx_Data;
                    state_d   = StDataL;
                end
                StDataL: begin
                    data_lo_d = Rx_Data;
                    state_d   = StChk;
                end
                StChk: begin
                    if (frame_sum(addr_q, data_hi_q, data_lo_q) == Rx_Data) begin
                        wr_d       = 1'b1;
                        m_addr_d   = addr_q;
                        m_wrdata_d = {data_hi_q, data_lo_q};
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_hi_q  <= '0;
            data_lo_q  <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            m_addr_q   <= '0;
            m_wrdata_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_hi_q  <= data_hi_d;
            data_lo_q  <= data_lo_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            m_addr_q   <= m_addr_d;
            m_wrdata_q <= m_wrdata_d;
        end
    end

    assign m_wr      = wr_q;
    assign m_addr    = m_addr_q;
    assign m_wrdata  = m_wrdata_q;
    assign Frame_Err = err_q;
    assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a short timeout and 20-cycle byte spacing.
module tb_uart_cmd_parser;

    localparam int unsigned TimeoutCycles = 100;
    localparam int unsigned Gap           = 19;

    logic        Clk;
    logic        Rst;
    logic [7:0]  Rx_Data;
    logic        Rx_Done;
    logic        m_wr;
    logic [7:0]  m_addr;
    logic [15:0] m_wrdata;
    logic        Frame_Err;
    logic        Busy;

    int n_total = 0;
    int n_pass  = 0;

    // Monitor state: cycles seen with each pulse high.
    int wr_cycles  = 0;
    int err_cycles = 0;

    // Snapshot of outputs in the cycle right after the last strobe.
    logic post_wr, post_err, post_busy;

    uart_cmd_parser #(
        .HEADER         (8'h55),
        .TIMEOUT_CYCLES (TimeoutCycles),
        .TO_W           (7)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Rx_Data   (Rx_Data),
        .Rx_Done   (Rx_Done),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wrdata  (m_wrdata),
        .Frame_Err (Frame_Err),
        .Busy      (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (m_wr === 1'b1) wr_cycles++;
        if (Frame_Err === 1'b1) err_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: strobe one byte, capture the following cycle, then idle.
    task automatic send_byte(input logic [7:0] b, input int gap);
        Rx_Data = b;
        Rx_Done = 1'b1;
        @(negedge Clk);
        post_wr   = m_wr;
        post_err  = Frame_Err;
        post_busy = Busy;
        Rx_Done   = 1'b0;
        Rx_Data   = 8'h00;
        repeat (gap) @(negedge Clk);
    endtask

    initial begin
        int wr_base;
        int err_base;
        int cnt;

        Rst     = 1'b1;
        Rx_Done = 1'b0;
        Rx_Data = 8'h00;
        repeat (2) @(negedge Clk);
        check("rst_m_wr", {31'd0, m_wr}, 32'd0);
        check("rst_m_addr", {24'd0, m_addr}, 32'd0);
        check("rst_m_wrdata", {16'd0, m_wrdata}, 32'd0);
        check("rst_frame_err", {31'd0, Frame_Err}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);

        // 1: single valid frame
        wr_base = wr_cycles; err_base = err_cycles;
        send_byte(8'h55, Gap);
        check("t1_busy_after_hdr", {31'd0, post_busy}, 32'd1);
        send_byte(8'h07, Gap);
        send_byte(8'h00, Gap);
        send_byte(8'h83, Gap);
        check("t1_busy_before_chk", {31'd0, Busy}, 32'd1);
        send_byte(8'h8A, 0);
        check("t1_wr_latency", {31'd0, post_wr}, 32'd1);
        check("t1_busy_after_chk", {31'd0, post_busy}, 32'd0);
        repeat (Gap) @(negedge Clk);
        check("t1_wr_count", wr_cycles - wr_base, 32'd1);
        check("t1_err_count", err_cycles - err_base, 32'd0);
        check("t1_addr", {24'd0, m_addr}, 32'h07);
        check("t1_data", {16'd0, m_wrdata}, 32'h0083);

        // 2: back-to-back frames
        wr_base = wr_cycles;
        send_byte(8'h55, Gap);
        send_byte(8'h08, Gap);
        send_byte(8'h12, Gap);
        send_byte(8'hB0, Gap);
        send_byte(8'hCA, 0);
        send_byte(8'h55, Gap);
        send_byte(8'h0C, Gap);
        send_byte(8'h00, Gap);
        check("t2_hold_addr", {24'd0, m_addr}, 32'h08);
        check("t2_hold_data", {16'd0, m_wrdata}, 32'h12B0);
        send_byte(8'h01, Gap);
        send_byte(8'h0D, Gap);
        check("t2_wr_count", wr_cycles - wr_base, 32'd2);
        check("t2_addr", {24'd0, m_addr}, 32'h0C);
        check("t2_data", {16'd0, m_wrdata}, 32'h0001);

        // 3: bad checksum
        wr_base = wr_cycles; err_base = err_cycles;
        send_byte(8'h55, Gap);
        send_byte(8'h06, Gap);
        send_byte(8'h00, Gap);
        send_byte(8'h01, Gap);
        send_byte(8'h00, Gap);
        check("t3_err_pulse", {31'd0, post_err}, 32'd1);
        check("t3_err_count", err_cycles - err_base, 32'd1);
        check("t3_wr_count", wr_cycles - wr_base, 32'd0);
        check("t3_addr_kept", {24'd0, m_addr}, 32'h0C);
        check("t3_data_kept", {16'd0, m_wrdata}, 32'h0001);
        check("t3_busy", {31'd0, Busy}, 32'd0);

        // 4: leading garbage ignored
        wr_base = wr_cycles; err_base = err_cycles;
        send_byte(8'hAA, Gap);
        send_byte(8'h13, Gap);
        check("t4_garbage_busy", {31'd0, Busy}, 32'd0);
        check("t4_garbage_err", err_cycles - err_base, 32'd0);
        send_byte(8'h55, Gap);
        send_byte(8'h06, Gap);
        send_byte(8'h00, Gap);
        send_byte(8'h01, Gap);
        send_byte(8'h07, Gap);
        check("t4_wr_count", wr_cycles - wr_base, 32'd1);
        check("t4_addr", {24'd0, m_addr}, 32'h06);
        check("t4_data", {16'd0, m_wrdata}, 32'h0001);

        // 5: inter-byte timeout
        err_base = err_cycles;
        send_byte(8'h55, Gap);
        send_byte(8'h07, 0);
        cnt = 0;
        while (Frame_Err !== 1'b1 && cnt < 3 * TimeoutCycles) begin
            @(posedge Clk);
            #1;
            cnt++;
        end
        check("t5_timeout_cycles", cnt, TimeoutCycles);
        check("t5_busy_dropped", {31'd0, Busy}, 32'd0);
        @(posedge Clk);
        #1;
        check("t5_err_single", {31'd0, Frame_Err}, 32'd0);
        @(negedge Clk);
        repeat (Gap) @(negedge Clk);
        check("t5_err_count", err_cycles - err_base, 32'd1);
        wr_base = wr_cycles;
        send_byte(8'h55, Gap);
        send_byte(8'h09, Gap);
        send_byte(8'h00, Gap);
        send_byte(8'h10, Gap);
        send_byte(8'h19, Gap);
        check("t5_wr_count", wr_cycles - wr_base, 32'd1);
        check("t5_addr", {24'd0, m_addr}, 32'h09);
        check("t5_data", {16'd0, m_wrdata}, 32'h0010);

        // 5b: byte arrives exactly on the terminal-count cycle
        wr_base = wr_cycles; err_base = err_cycles;
        send_byte(8'h55, Gap);
        send_byte(8'h07, 0);
        repeat (TimeoutCycles - 1) @(negedge Clk);
        send_byte(8'h00, Gap);
        check("t5b_busy_kept", {31'd0, post_busy}, 32'd1);
        send_byte(8'h83, Gap);
        send_byte(8'h8A, Gap);
        check("t5b_no_timeout", err_cycles - err_base, 32'd0);
        check("t5b_wr_count", wr_cycles - wr_base, 32'd1);
        check("t5b_data", {16'd0, m_wrdata}, 32'h0083);

        // 6: reset mid-frame
        wr_base = wr_cycles; err_base = err_cycles;
        send_byte(8'h55, Gap);
        send_byte(8'h07, Gap);
        send_byte(8'h00, Gap);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check("t6_addr_cleared", {24'd0, m_addr}, 32'h00);
        check("t6_data_cleared", {16'd0, m_wrdata}, 32'h0000);
        check("t6_busy_cleared", {31'd0, Busy}, 32'd0);
        send_byte(8'h83, Gap);
        send_byte(8'h8A, 2 * TimeoutCycles);
        check("t6_no_wr", wr_cycles - wr_base, 32'd0);
        check("t6_no_err", err_cycles - err_base, 32'd0);
        send_byte(8'h55, Gap);
        send_byte(8'h07, Gap);
        send_byte(8'h00, Gap);
        send_byte(8'h83, Gap);
        send_byte(8'h8A, Gap);
        check("t6_wr_after", wr_cycles - wr_base, 32'd1);
        check("t6_addr_after", {24'd0, m_addr}, 32'h07);
        check("t6_data_after", {16'd0, m_wrdata}, 32'h0083);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Host-side initiator of the register-write bus (m_wr/m_addr/m_wrdata) consumed by the DDS control block and its sibling register blocks.
- Takes bytes from the UART receiver and assembles 5-byte command frames: header, address, data high byte, data low byte, checksum.
- On a valid frame, issues exactly one single-cycle register write.
- Rejects corrupt or stalled frames and reports them on an error pulse.

Parameters:
- HEADER, 8'h55, frame start byte.
- TIMEOUT_CYCLES, 500000, max Clk cycles allowed between consecutive frame bytes (10 ms at 50 MHz); must be >= 2.
- TO_W, 19, timeout counter width; 2^TO_W must exceed TIMEOUT_CYCLES.

Ports:
- Clk  input  1  system clock.
- Rst  input  1  synchronous reset, active-high.
- Rx_Data  input  8  received byte; valid only while Rx_Done=1.
- Rx_Done  input  1  single-cycle strobe, one new byte.
- m_wr  output  1  register write strobe, one cycle per accepted frame.
- m_addr  output  8  register address.
- m_wrdata  output  16  register write data {data_hi, data_lo}.
- Frame_Err  output  1  single-cycle pulse on checksum failure or inter-byte timeout.
- Busy  output  1  high while a frame is partially received (state != IDLE).

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high (Clk, Rst).
  - While Rst=1 at a Clk edge: state=IDLE, m_wr=0, m_addr=0, m_wrdata=0, Frame_Err=0, Busy=0, timeout counter=0, internal byte registers=0.
  - Reset mid-frame discards the partial frame; no write and no Frame_Err result from it.
- FSM states: IDLE, ADDR, DATA_H, DATA_L, CHK.
  - IDLE: on Rx_Done with Rx_Data==HEADER -> ADDR. Any other byte is silently ignored (no Frame_Err).
  - ADDR: on Rx_Done, latch addr -> DATA_H.
  - DATA_H: on Rx_Done, latch data_hi -> DATA_L.
  - DATA_L: on Rx_Done, latch data_lo -> CHK.
  - CHK: on Rx_Done, compare Rx_Data against (addr + data_hi + data_lo) mod 256 (8-bit truncating sum). Always -> IDLE.
- Outcome of the CHK comparison, registered on the next edge:
  - Match: m_wr=1 for exactly one cycle; m_addr=addr and m_wrdata={data_hi,data_lo} update on the same edge.
  - Mismatch: Frame_Err=1 for one cycle; m_wr, m_addr and m_wrdata unchanged.
- Latency: m_wr asserts on the first Clk edge after the edge sampling the checksum byte's Rx_Done (one-cycle latency).
- m_addr and m_wrdata hold their values between writes. They are never driven with partial frame data.
- A HEADER value received in ADDR..CHK is treated as ordinary payload; there is no resynchronisation mid-frame.
- Timeout:
  - The counter clears on every Rx_Done and while in IDLE; otherwise it increments by 1 per cycle.
  - When counter == TIMEOUT_CYCLES-1 and no Rx_Done in that cycle: -> IDLE, Frame_Err pulse, counter clears.
  - If Rx_Done coincides with the terminal count, Rx_Done wins: the byte is processed and no timeout occurs.
- Busy is combinational from state (state != IDLE).
- Back-to-back frames are allowed. A header byte in the cycle right after CHK is accepted normally, because the UART strobe spacing exceeds 1 cycle.
- Rx_Done is never asserted on consecutive cycles (UART guarantee). Bench need not stress this.

Decomposition:
- Shared package (uart_cmd_pkg):
  - state encoding constants: IDLE=0, ADDR=1, DATA_H=2, DATA_L=3, CHK=4 (3-bit).
  - default HEADER.
  - frame length 5.
  - the register address constants already used by the DDS register block (DDS_En=6, Fword_H=7, Fword_L=8, Pword=9, S_Cnt_Max_L=10, S_Cnt_Max_H=11, Sample_En=12), so host software and RTL share one map.
- One sub-module is natural: uart_cmd_timeout. It is a parameterised counter with a clear input and a terminal-count pulse output, instantiated once.

Test Plan (TIMEOUT_CYCLES=100 for bench; byte strobes spaced 20 cycles):
1. Bytes 55 07 00 83 8A -> one m_wr pulse 1 cycle after the 5th strobe, m_addr=8'h07, m_wrdata=16'h0083, Frame_Err never asserted; Busy high from 1st to 5th strobe.
2. Bytes 55 08 12 B0 CA then immediately 55 0C 00 01 0D -> two m_wr pulses: (08, 12B0) then (0C, 0001); m_addr/m_wrdata hold 08/12B0 between them.
3. Bytes 55 06 00 01 00 (bad checksum, expected 07) -> Frame_Err single pulse, no m_wr, m_addr/m_wrdata keep prior values, Busy low after.
4. Bytes AA 13 55 06 00 01 07 -> leading AA, 13 ignored with no Frame_Err; one write m_addr=06, m_wrdata=0001.
5. Bytes 55 07, then silence -> Frame_Err pulses exactly 100 cycles after the 07 strobe, Busy drops; a following valid frame 55 09 00 10 19 writes (09, 0010). Variant: 3rd byte strobed on the terminal-count cycle -> no timeout.
6. Bytes 55 07 00, assert Rst 1 cycle, then 83 8A -> no m_wr, no Frame_Err, outputs all 0; a full frame 55 07 00 83 8A afterwards writes normally.
